// File: rtl/alu_pkg.sv
// Shared types and constants for the sequential shifter.
package alu_pkg;

  localparam int unsigned XLEN = 32;

  typedef enum logic [1:0] {
    SLL = 2'b00,
    SRL = 2'b01,
    SRA = 2'b11
  } shift_op_t;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } state_t;

  function automatic logic [4:0] min_amt(input logic [4:0] x, input logic [4:0] y);
    return (x < y) ? x : y;
  endfunction

endpackage

// File: rtl/shift_seq_ctrl_if.sv
// Request/response bundle between a requester and the sequential shifter.
interface shift_seq_ctrl_if;
  import alu_pkg::*;

  logic            start;
  logic [1:0]      op;
  logic [XLEN-1:0] a;
  logic [XLEN-1:0] b;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;

  modport master (output start, output op, output a, output b,
                  input busy, input done, input result);
  modport slave  (input start, input op, input a, input b,
                  output busy, output done, output result);
endinterface

// File: rtl/shift_step.sv
// One combinational shift of at most STEP positions.
module shift_step
  import alu_pkg::*;
#(
  parameter int unsigned STEP = 1
) (
  input  logic [XLEN-1:0] data,
  input  logic [4:0]      amt,
  input  shift_op_t       op,
  output logic [XLEN-1:0] out
);

  localparam logic [4:0] STEP_W = 5'(STEP);

  logic [4:0] amt_c;

  always_comb begin
    amt_c = min_amt(amt, STEP_W);
    case (op)
      SRL:     out = data >> amt_c;
      SRA:     out = $signed(data) >>> amt_c;
      // the reserved encoding 2'b10 shifts left like SLL
      default: out = data << amt_c;
    endcase
  end

endmodule

// File: rtl/shift_seq_ctrl.sv
// Multi-cycle barrel-free shifter: shifts by up to STEP bits per cycle.
module shift_seq_ctrl
  import alu_pkg::*;
#(
  parameter int unsigned STEP = 1
) (
  input logic             clk,
  input logic             rst_n,
  shift_seq_ctrl_if.slave bus
);

  localparam logic [4:0] STEP_W = 5'(STEP);

  state_t          state;
  shift_op_t       op_q;
  logic [XLEN-1:0] work;
  logic [4:0]      rem;
  logic [4:0]      k;
  logic [XLEN-1:0] step_out;

  always_comb k = min_amt(rem, STEP_W);

  shift_step #(.STEP(STEP)) u_step (
    .data (work),
    .amt  (k),
    .op   (op_q),
    .out  (step_out)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      op_q       <= SLL;
      work       <= '0;
      rem        <= '0;
      bus.busy   <= 1'b0;
      bus.done   <= 1'b0;
      bus.result <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          bus.done <= 1'b0;
          if (bus.start) begin
            work <= bus.a;
            op_q <= shift_op_t'(bus.op);
            rem  <= bus.b[4:0];
            // zero shift amount skips SHIFT and publishes the operand directly
            if (bus.b[4:0] == 5'd0) begin
              state      <= DONE;
              bus.busy   <= 1'b0;
              bus.done   <= 1'b1;
              bus.result <= bus.a;
            end else begin
              state    <= SHIFT;
              bus.busy <= 1'b1;
            end
          end else begin
            state    <= IDLE;
            bus.busy <= 1'b0;
          end
        end
        SHIFT: begin
          work <= step_out;
          rem  <= rem - k;
          if (rem == k) begin
            state      <= DONE;
            bus.busy   <= 1'b0;
            bus.done   <= 1'b1;
            bus.result <= step_out;
          end
        end
        default: begin
          state    <= IDLE;
          bus.busy <= 1'b0;
          bus.done <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Drives identical traffic into STEP=1 and STEP=4 shifters and checks both.
module tb_shift_seq_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  shift_seq_ctrl_if if1 ();
  shift_seq_ctrl_if if4 ();

  shift_seq_ctrl #(.STEP(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1.slave));
  shift_seq_ctrl #(.STEP(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(if4.slave));

  typedef struct {
    string       name;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat1;
    int          lat4;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic drive(input logic s, input logic [1:0] o, input logic [31:0] av, input logic [31:0] bv);
    if1.start = s; if1.op = o; if1.a = av; if1.b = bv;
    if4.start = s; if4.op = o; if4.a = av; if4.b = bv;
  endtask

  // Reference: the whole shift in one go, as the operation is defined.
  function automatic logic [31:0] ref_shift(input logic [1:0] o, input logic [31:0] av, input int n);
    logic signed [31:0] s;
    s = av;
    case (o)
      2'b01:   return av >> n;
      2'b11:   return s >>> n;
      default: return av << n;
    endcase
  endfunction

  function automatic int ref_lat(input int n, input int step);
    return (n + step - 1) / step + 1;
  endfunction

  // Called at a negedge with both DUTs idle; returns at a negedge with both idle.
  task automatic do_op(input string tag, input logic [1:0] o, input logic [31:0] av,
                       input logic [31:0] bv, input logic [31:0] exp, input int l1, input int l4);
    logic [31:0] old1, old4;
    int lat1 = 0, lat4 = 0, dn1 = 0, dn4 = 0, bz1 = 0, bz4 = 0;
    int hold1 = 1, hold4 = 1;
    int window;
    old1 = if1.result;
    old4 = if4.result;
    window = ((l1 > l4) ? l1 : l4) + 3;
    drive(1'b1, o, av, bv);
    @(posedge clk);
    @(negedge clk);
    drive(1'b0, 2'b00, '0, '0);
    for (int cyc = 1; cyc <= window; cyc++) begin
      if (if1.done) begin dn1++; if (lat1 == 0) lat1 = cyc; end
      if (if4.done) begin dn4++; if (lat4 == 0) lat4 = cyc; end
      if (if1.busy) bz1++;
      if (if4.busy) bz4++;
      if (lat1 == 0 && if1.result !== old1) hold1 = 0;
      if (lat4 == 0 && if4.result !== old4) hold4 = 0;
      // scramble the inputs: the operation in flight must not see them
      drive(1'b0, 2'($urandom_range(0, 3)), $urandom, $urandom);
      @(negedge clk);
    end
    drive(1'b0, 2'b00, '0, '0);
    chk({tag, " s1 result"}, if1.result, exp);
    chk({tag, " s4 result"}, if4.result, exp);
    chk({tag, " s1 latency"}, 32'(lat1), 32'(l1));
    chk({tag, " s4 latency"}, 32'(lat4), 32'(l4));
    chk({tag, " s1 busy cycles"}, 32'(bz1), 32'(l1 - 1));
    chk({tag, " s4 busy cycles"}, 32'(bz4), 32'(l4 - 1));
    chk({tag, " s1 done pulses"}, 32'(dn1), 32'd1);
    chk({tag, " s4 done pulses"}, 32'(dn4), 32'd1);
    chk({tag, " s1 result hold"}, 32'(hold1), 32'd1);
    chk({tag, " s4 result hold"}, 32'(hold4), 32'd1);
  endtask

  // Wait for done on the STEP=1 instance; cyc is the cycle count so far.
  task automatic wait_done1(input int cyc0, output int lat);
    lat = 0;
    for (int cyc = cyc0; cyc <= 60; cyc++) begin
      if (if1.done) begin lat = cyc; break; end
      @(negedge clk);
    end
  endtask

  initial begin
    int lat;
    int dn;
    drive(1'b0, 2'b00, '0, '0);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset s1 busy", 32'(if1.busy), 32'd0);
    chk("reset s1 done", 32'(if1.done), 32'd0);
    chk("reset s1 result", if1.result, 32'd0);
    chk("reset s4 busy", 32'(if4.busy), 32'd0);
    chk("reset s4 done", 32'(if4.done), 32'd0);
    chk("reset s4 result", if4.result, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    vecs.push_back('{"sll31",   2'b00, 32'h0000_0001, 32'd31, 32'h8000_0000, 32, 9});
    vecs.push_back('{"sra4",    2'b11, 32'h8000_0000, 32'd4,  32'hF800_0000, 5, 2});
    vecs.push_back('{"srl4",    2'b01, 32'h8000_0000, 32'd4,  32'h0800_0000, 5, 2});
    vecs.push_back('{"b0",      2'b00, 32'hDEAD_BEEF, 32'd0,  32'hDEAD_BEEF, 1, 1});
    vecs.push_back('{"b32",     2'b11, 32'hDEAD_BEEF, 32'd32, 32'hDEAD_BEEF, 1, 1});
    vecs.push_back('{"sll36",   2'b00, 32'h0000_0003, 32'd36, 32'd48,        5, 2});
    vecs.push_back('{"rsv",     2'b10, 32'h0000_0001, 32'd3,  32'h0000_0008, 4, 2});
    vecs.push_back('{"sra_pos", 2'b11, 32'h7FFF_FFF0, 32'd4,  32'h07FF_FFFF, 5, 2});
    vecs.push_back('{"sra17",   2'b11, 32'hF000_0000, 32'd17, 32'hFFFF_F800, 18, 6});
    vecs.push_back('{"srl16",   2'b01, 32'hFFFF_0000, 32'd16, 32'h0000_FFFF, 17, 5});
    foreach (vecs[i])
      do_op(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].lat1, vecs[i].lat4);

    for (int i = 0; i < 60; i++) begin
      logic [1:0]  o;
      logic [31:0] av, bv;
      int n;
      o  = 2'($urandom_range(0, 3));
      av = $urandom;
      bv = $urandom;
      n  = int'(bv[4:0]);
      do_op("rand", o, av, bv, ref_shift(o, av, n), ref_lat(n, 1), ref_lat(n, 4));
    end

    // second start during SHIFT is dropped (STEP=1 instance)
    drive(1'b1, 2'b00, 32'd5, 32'd8);
    @(posedge clk); @(negedge clk);
    drive(1'b0, 2'b00, '0, '0);
    @(negedge clk); @(negedge clk);
    drive(1'b1, 2'b01, 32'hFFFF_FFFF, 32'd1);
    @(posedge clk); @(negedge clk);
    drive(1'b0, 2'b00, '0, '0);
    wait_done1(4, lat);
    chk("midstart latency", 32'(lat), 32'd9);
    chk("midstart result", if1.result, 32'h0000_0500);
    repeat (3) @(negedge clk);

    // reset in SHIFT cycle 3, with start asserted during the reset cycle
    drive(1'b1, 2'b00, 32'd1, 32'd10);
    @(posedge clk); @(negedge clk);
    drive(1'b0, 2'b00, '0, '0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b0;
    drive(1'b1, 2'b00, 32'd7, 32'd5);
    @(posedge clk); @(negedge clk);
    chk("abort s1 busy", 32'(if1.busy), 32'd0);
    chk("abort s1 done", 32'(if1.done), 32'd0);
    chk("abort s1 result", if1.result, 32'd0);
    chk("abort s4 busy", 32'(if4.busy), 32'd0);
    chk("abort s4 done", 32'(if4.done), 32'd0);
    chk("abort s4 result", if4.result, 32'd0);
    rst_n = 1'b1;
    drive(1'b0, 2'b00, '0, '0);
    dn = 0;
    for (int i = 0; i < 30; i++) begin
      if (if1.done || if4.done || if1.busy || if4.busy) dn++;
      @(negedge clk);
    end
    chk("abort no activity", 32'(dn), 32'd0);

    // back-to-back: start held in DONE is accepted with no IDLE gap
    drive(1'b1, 2'b00, 32'd1, 32'd2);
    @(posedge clk); @(negedge clk);
    drive(1'b0, 2'b00, '0, '0);
    wait_done1(1, lat);
    chk("b2b first latency", 32'(lat), 32'd3);
    chk("b2b first result", if1.result, 32'd4);
    drive(1'b1, 2'b01, 32'h0000_0100, 32'd4);
    @(posedge clk); @(negedge clk);
    chk("b2b no gap busy", 32'(if1.busy), 32'd1);
    chk("b2b no gap done", 32'(if1.done), 32'd0);
    drive(1'b0, 2'b00, '0, '0);
    wait_done1(1, lat);
    chk("b2b second latency", 32'(lat), 32'd5);
    chk("b2b second result", if1.result, 32'h0000_0010);
    @(negedge clk);
    chk("b2b done pulse end", 32'(if1.done), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/shift_seq_ctrl.md
SHIFT_SEQ_CTRL -- requirements
Module: shift_seq_ctrl

Interface
REQ-001 Parameter: STEP, default 1, the maximum shift distance applied per SHIFT cycle; legal values are 1, 2, 4, 8 and 16.
REQ-002 clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  reset, synchronous and active-low.
REQ-004 start  input  1  request to begin an operation; sampled only when the block can accept.
REQ-005 op  input  2  operation: 00 SLL, 01 SRL, 11 SRA, 10 reserved (executes as SLL).
REQ-006 a  input  32  operand to be shifted.
REQ-007 b  input  32  shift amount; only b[4:0] is used.
REQ-008 busy  output  1  high while an accepted operation is in the SHIFT state.
REQ-009 done  output  1  one-cycle pulse marking that result is valid.
REQ-010 result  output  32  final shifted value; held until the next DONE.

Function
REQ-011 The block SHALL implement three states: IDLE, SHIFT and DONE.
REQ-012 start SHALL be accepted in IDLE or DONE; in SHIFT it SHALL be ignored, with no queuing.
REQ-013 On acceptance, the block SHALL latch a, op and b[4:0] into internal registers: work, op_q and rem.
REQ-014 On acceptance with b[4:0]=0, the next state SHALL be DONE; otherwise it SHALL be SHIFT.
REQ-015 Each SHIFT cycle SHALL shift work by k=min(STEP, rem) in the direction given by op_q, and SHALL set rem to rem-k.
REQ-016 When rem-k=0 in a SHIFT cycle, the next state SHALL be DONE; otherwise the state SHALL remain SHIFT.
REQ-017 SLL SHALL zero-fill from the right, SRL SHALL zero-fill from the left, and SRA SHALL fill from the left with bit 31 of the latched a.
REQ-018 On entering DONE, result SHALL load the final work value; done SHALL be 1 exactly in the DONE cycle.
REQ-019 With start absent in DONE, the next state SHALL be IDLE.
REQ-020 With start present in DONE, the block SHALL accept it as in IDLE, giving back-to-back operation.
REQ-021 busy SHALL equal (state==SHIFT).
REQ-022 The latency from the accepting edge to done=1 SHALL be ceil(shamt/STEP)+1 cycles.
REQ-023 result SHALL not change in SHIFT or IDLE; intermediate values SHALL stay internal.
REQ-024 Changes on a, b and op after acceptance SHALL have no effect on the operation in flight.

Reset
REQ-025 When rst_n=0 at a clock edge, the state SHALL become IDLE and busy, done and result SHALL be 0.
REQ-026 A reset during SHIFT SHALL abort the operation; no done pulse SHALL follow.
REQ-027 start SHALL be ignored in any cycle with rst_n=0.

Structure
REQ-028 alu_pkg SHALL hold shift_op_t (SLL=2'b00, SRL=2'b01, SRA=2'b11), the state enum and the XLEN=32 constant.
REQ-029 A combinational sub-module shift_step SHALL perform one shift of at most STEP, with inputs data, amt and op and output out; shift_seq_ctrl SHALL instantiate it once.
REQ-030 The rem register SHALL be 5 bits wide; no decrement SHALL underflow.

Verification
REQ-031 STEP=1, SLL, a=32'h1, b=31, start for 1 cycle -> busy for 31 cycles, done on cycle 32, result=32'h8000_0000.
REQ-032 STEP=1, SRA, a=32'h8000_0000, b=4 -> done 5 cycles after start, result=32'hF800_0000; the same with SRL -> 32'h0800_0000.
REQ-033 b=0 and b=32 (b[4:0]=0), a=32'hDEAD_BEEF -> busy never high, done on the next cycle, result=32'hDEAD_BEEF.
REQ-034 STEP=4, SLL, a=3, b=36 (shamt 4) -> done 2 cycles after start, result=48.
REQ-035 A second start mid-SHIFT is ignored and the first result stays correct; start held high in DONE -> next op accepted with no IDLE gap.
REQ-036 rst_n=0 for 1 cycle at SHIFT cycle 3 of a b=10 op -> busy=0, done=0 and result=0 after the next edge, and no done pulse follows.
